// File: rtl/rgb_gray_stream.sv
// Streaming RGB-to-grayscale converter with a two-stage pipeline.
// Raster tags and the per-frame mode travel alongside each pixel.
module rgb_gray_stream #(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 500,
    parameter int IMG_H  = 500,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_r,
    input  logic [PIX_W-1:0]  in_g,
    input  logic [PIX_W-1:0]  in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_pix,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int AW = PIX_W + 10;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    localparam logic [AW-1:0] K_R   = AW'(77);
    localparam logic [AW-1:0] K_G   = AW'(150);
    localparam logic [AW-1:0] K_B   = AW'(29);
    localparam logic [AW-1:0] K_AVG = AW'(85);
    localparam logic [AW-1:0] K_RND = AW'(128);

    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [FCNT_W-1:0] r_fcnt;
    logic [1:0]        r_mode;

    logic              r_s1_v;
    logic [1:0]        r_s1_mode;
    logic [AW-1:0]     r_s1_pr;
    logic [AW-1:0]     r_s1_pg;
    logic [AW-1:0]     r_s1_pb;
    logic [AW-1:0]     r_s1_sum;
    logic [PIX_W-1:0]  r_s1_max;
    logic [PIX_W-1:0]  r_s1_r;
    logic              r_s1_sof;
    logic              r_s1_eol;
    logic              r_s1_eof;

    logic              r_out_valid;
    logic [PIX_W-1:0]  r_out_pix;
    logic              r_out_sof;
    logic              r_out_eol;
    logic              r_out_eof;

    logic              w_en;
    logic              w_acc;
    logic              w_first;
    logic              w_xlast;
    logic              w_ylast;
    logic [1:0]        w_mode;
    logic [PIX_W-1:0]  w_max;
    logic [AW-1:0]     w_luma;
    logic [AW-1:0]     w_avg;
    logic [PIX_W-1:0]  w_pix;

    // The whole pipe advances as one unit whenever the output slot can move.
    assign w_en     = !r_out_valid || out_ready;
    assign w_acc    = in_valid && w_en;
    assign in_ready = w_en;

    assign w_first = (r_x == '0) && (r_y == '0);
    assign w_xlast = (r_x == X_LAST);
    assign w_ylast = (r_y == Y_LAST);
    // Pixel (0,0) already uses the freshly sampled mode.
    assign w_mode  = w_first ? mode : r_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_fcnt <= '0;
            r_mode <= 2'd0;
        end else if (w_acc) begin
            if (w_first) begin
                r_mode <= mode;
            end
            if (w_xlast) begin
                r_x <= '0;
                if (w_ylast) begin
                    r_y    <= '0;
                    r_fcnt <= r_fcnt + FCNT_W'(1);
                end else begin
                    r_y <= r_y + YW'(1);
                end
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    always_comb begin
        w_max = in_r;
        if (in_g > w_max) w_max = in_g;
        if (in_b > w_max) w_max = in_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_mode <= 2'd0;
            r_s1_pr   <= '0;
            r_s1_pg   <= '0;
            r_s1_pb   <= '0;
            r_s1_sum  <= '0;
            r_s1_max  <= '0;
            r_s1_r    <= '0;
            r_s1_sof  <= 1'b0;
            r_s1_eol  <= 1'b0;
            r_s1_eof  <= 1'b0;
        end else if (w_en) begin
            r_s1_v    <= in_valid;
            r_s1_mode <= w_mode;
            r_s1_pr   <= AW'(in_r) * K_R;
            r_s1_pg   <= AW'(in_g) * K_G;
            r_s1_pb   <= AW'(in_b) * K_B;
            r_s1_sum  <= AW'(in_r) + AW'(in_g) + AW'(in_b);
            r_s1_max  <= w_max;
            r_s1_r    <= in_r;
            r_s1_sof  <= in_valid && w_first;
            r_s1_eol  <= in_valid && w_xlast;
            r_s1_eof  <= in_valid && w_xlast && w_ylast;
        end
    end

    assign w_luma = r_s1_pr + r_s1_pg + r_s1_pb + K_RND;
    assign w_avg  = r_s1_sum * K_AVG + K_RND;

    always_comb begin
        w_pix = '0;
        unique case (r_s1_mode)
            2'd0: w_pix = PIX_W'(w_luma >> 8);
            2'd1: w_pix = PIX_W'(w_avg >> 8);
            2'd2: w_pix = r_s1_max;
            2'd3: w_pix = r_s1_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_pix   <= '0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_out_eof   <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_s1_v;
            r_out_pix   <= w_pix;
            r_out_sof   <= r_s1_sof;
            r_out_eol   <= r_s1_eol;
            r_out_eof   <= r_s1_eof;
        end
    end

    assign out_valid = r_out_valid;
    assign out_pix   = r_out_pix;
    assign out_sof   = r_out_sof;
    assign out_eol   = r_out_eol;
    assign out_eof   = r_out_eof;
    assign frame_cnt = r_fcnt;

endmodule
